piso_serial_tx: RTL and testbench

//  Parallel-in/serial-out framed transmitter.
//  - Transmit end for the team's SIPO shift-register receivers.
//  - Accepts an N-bit word via a load/ready handshake.
//  - Shifts the word out MSB first inside a start/parity/stop frame, one bit every DIV clocks.
//  - Bit timing comes from an internal down-counting tick timer; frame position from a bit down-counter.

---
 rtl/piso_serial_tx_if.sv | 22 ++
 rtl/piso_serial_tx.sv | 119 +++++++++++
 tb/tb_piso_serial_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/piso_serial_tx_if.sv
// Handshake and serial line bundle for the framed PISO transmitter.
// The master drives load/in; the slave (transmitter) drives status and sout.
interface piso_serial_tx_if #(
  parameter int N = 4
);
  logic         load;
  logic [N-1:0] in;
  logic         ready;
  logic         busy;
  logic         done;
  logic         sout;

  modport master (
    output load, in,
    input  ready, busy, done, sout
  );

  modport slave (
    input  load, in,
    output ready, busy, done, sout
  );
endinterface

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start, data MSB first,
// optional even parity, stop; each bit held DIV clocks.
module piso_serial_tx #(
  parameter int N         = 4,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic clk,
  input  logic rst,
  piso_serial_tx_if.slave tx
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);
  localparam logic [BW-1:0] LAST   = BW'(N - 1);

  logic [2:0]    state;
  logic [N-1:0]  sreg;
  logic          par;
  logic [TW-1:0] tick;
  logic [BW-1:0] bitcnt;
  logic          sout_q;
  logic          done_q;
  logic          tick_end;

  assign tick_end = (tick == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      par    <= 1'b0;
      tick   <= '0;
      bitcnt <= '0;
      sout_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          sout_q <= 1'b1;
          if (tx.load) begin
            sreg   <= tx.in;
            par    <= ^tx.in;
            tick   <= RELOAD;
            state  <= START;
            sout_q <= 1'b0;
          end
        end
        START: begin
          if (tick_end) begin
            tick   <= RELOAD;
            bitcnt <= LAST;
            state  <= DATA;
            sout_q <= sreg[N-1];
          end else begin
            tick <= tick - 1'b1;
          end
        end
        DATA: begin
          if (tick_end) begin
            tick   <= RELOAD;
            sreg   <= sreg << 1;
            bitcnt <= bitcnt - 1'b1;
            if (bitcnt == '0) begin
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                sout_q <= par;
              end else begin
                state  <= STOP;
                sout_q <= 1'b1;
              end
            end else begin
              // next data bit is the one just below the current MSB
              sout_q <= sreg[N-2];
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        PARITY: begin
          if (tick_end) begin
            tick   <= RELOAD;
            state  <= STOP;
            sout_q <= 1'b1;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        STOP: begin
          if (tick_end) begin
            tick   <= RELOAD;
            state  <= IDLE;
            sout_q <= 1'b1;
            done_q <= 1'b1;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          sout_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx.busy  = (state != IDLE);
  assign tx.ready = ~tx.busy;
  assign tx.done  = done_q;
  assign tx.sout  = sout_q;
endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: DUT A (N=4, DIV=4, parity on) and
// DUT B (N=4, DIV=1, parity off), checked against a frame-list model.
module tb_piso_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  piso_serial_tx_if #(.N(4)) ia ();
  piso_serial_tx_if #(.N(4)) ib ();

  piso_serial_tx #(.N(4), .DIV(4), .PARITY_EN(1)) dut_a (
    .clk(clk),
    .rst(rst),
    .tx (ia)
  );

  piso_serial_tx #(.N(4), .DIV(1), .PARITY_EN(0)) dut_b (
    .clk(clk),
    .rst(rst),
    .tx (ib)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic ld, input logic [3:0] w);
    if (sel == 0) begin
      ia.load = ld;
      ia.in   = w;
    end else begin
      ib.load = ld;
      ib.in   = w;
    end
  endtask

  task automatic status(input int sel, output logic so, output logic rd,
                        output logic bz, output logic dn);
    if (sel == 0) begin
      so = ia.sout; rd = ia.ready; bz = ia.busy; dn = ia.done;
    end else begin
      so = ib.sout; rd = ib.ready; bz = ib.busy; dn = ib.done;
    end
  endtask

  // Caller has already put load=1/in=w on the bus at a falling edge.
  // mode 0: load dropped; 1: random load/in noise; 2: load held with nw.
  task automatic frame(input int sel, input logic [3:0] w, input int mode,
                       input bit chain, input logic [3:0] nw);
    int div;
    int bits[$];
    logic so, rd, bz, dn;
    logic [3:0] rw;
    div = (sel == 0) ? 4 : 1;
    bits.delete();
    bits.push_back(0);
    for (int i = 3; i >= 0; i--) bits.push_back((w >> i) & 1);
    if (sel == 0) bits.push_back($countones(w) % 2);
    bits.push_back(1);
    @(posedge clk);
    for (int k = 0; k < bits.size() * div; k++) begin
      @(negedge clk);
      status(sel, so, rd, bz, dn);
      chk("sout", so, bits[k / div]);
      chk("busy", bz, 1);
      chk("ready", rd, 0);
      chk("done_early", dn, 0);
      rw = 4'($urandom);
      unique case (mode)
        1:       drive(sel, 1'($urandom), rw);
        2:       drive(sel, 1'b1, nw);
        default: drive(sel, 1'b0, rw);
      endcase
    end
    @(negedge clk);
    status(sel, so, rd, bz, dn);
    chk("done", dn, 1);
    chk("ready_end", rd, 1);
    chk("busy_end", bz, 0);
    chk("sout_end", so, 1);
    drive(sel, chain, nw);
  endtask

  task automatic idle_chk(input int sel);
    logic so, rd, bz, dn;
    @(negedge clk);
    status(sel, so, rd, bz, dn);
    chk("idle_sout", so, 1);
    chk("idle_ready", rd, 1);
    chk("idle_done", dn, 0);
  endtask

  initial begin
    logic [3:0] w, nw;
    logic       quiet;
    int         mode;
    bit         chain;
    ia.load = 1'b0; ia.in = '0;
    ib.load = 1'b0; ib.in = '0;

    // asynchronous reset, no clock edge between assertion and check
    #3 rst = 1'b1;
    #1;
    chk("rst_sout", ia.sout, 1);
    chk("rst_ready", ia.ready, 1);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_sout_b", ib.sout, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_chk(0);

    // directed frame 1011, parity 1
    drive(0, 1'b1, 4'b1011);
    frame(0, 4'b1011, 0, 1'b0, 4'b0000);
    idle_chk(0);

    // 0110 then back-to-back 1111 accepted in the done cycle
    drive(0, 1'b1, 4'b0110);
    frame(0, 4'b0110, 0, 1'b1, 4'b1111);
    frame(0, 4'b1111, 0, 1'b0, 4'b0000);
    idle_chk(0);

    // load held during frame is ignored
    drive(0, 1'b1, 4'b1001);
    frame(0, 4'b1001, 2, 1'b0, 4'b0110);
    idle_chk(0);
    idle_chk(0);

    // reset in the second data bit aborts the frame without done
    drive(0, 1'b1, 4'b1010);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 4'b0000);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sout", ia.sout, 1);
    chk("abort_ready", ia.ready, 1);
    chk("abort_done", ia.done, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (ia.done !== 1'b0 || ia.sout !== 1'b1) quiet = 1'b0;
    end
    chk("abort_quiet", quiet, 1);
    drive(0, 1'b1, 4'b0011);
    frame(0, 4'b0011, 0, 1'b0, 4'b0000);
    idle_chk(0);

    // randomized frames, noise and chaining on DUT A
    w = 4'($urandom);
    drive(0, 1'b1, w);
    for (int i = 0; i < 10; i++) begin
      nw    = 4'($urandom);
      mode  = (i == 9) ? 0 : int'($urandom_range(0, 1));
      chain = (i != 9) && ($urandom_range(0, 1) == 1);
      frame(0, w, mode, chain, nw);
      if (!chain) begin
        idle_chk(0);
        if (i != 9) drive(0, 1'b1, nw);
      end
      w = nw;
    end

    // DUT B: DIV=1, no parity
    @(negedge clk);
    drive(1, 1'b1, 4'b1001);
    frame(1, 4'b1001, 0, 1'b0, 4'b0000);
    idle_chk(1);
    for (int i = 0; i < 6; i++) begin
      w  = 4'($urandom);
      nw = 4'($urandom);
      drive(1, 1'b1, w);
      frame(1, w, int'($urandom_range(0, 1)), 1'b0, nw);
      idle_chk(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
